// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side signal bundle for the hazard controller: DECODE/EXECUTE
// hazard sources in, stall/flush/multiplier status out.
interface pipeline_hazard_controller_if #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int COUNT_WIDTH    = 16
);
   logic [REG_ADDR_WIDTH-1:0] source1_DECODE;
   logic [REG_ADDR_WIDTH-1:0] source2_DECODE;
   logic [REG_ADDR_WIDTH-1:0] store_DECODE;
   logic                      mul_op_DECODE;
   logic [REG_ADDR_WIDTH-1:0] destination_EXECUTE;
   logic                      memread_EXECUTE;
   logic                      mul_start_EXECUTE;
   logic                      branch_taken_EXECUTE;

   logic                      stall_FETCH;
   logic                      stall_DECODE;
   logic                      bubble_EXECUTE;
   logic                      flush_FETCH;
   logic                      flush_DECODE;
   logic                      mul_busy;
   logic                      mul_done;
   logic [COUNT_WIDTH-1:0]    stall_cycles;
   logic                      protocol_error;

   // Pipeline side: drives hazard sources, observes control outputs.
   modport master (
      output source1_DECODE, source2_DECODE, store_DECODE, mul_op_DECODE,
             destination_EXECUTE, memread_EXECUTE, mul_start_EXECUTE,
             branch_taken_EXECUTE,
      input  stall_FETCH, stall_DECODE, bubble_EXECUTE, flush_FETCH,
             flush_DECODE, mul_busy, mul_done, stall_cycles, protocol_error
   );

   // Controller side.
   modport slave (
      input  source1_DECODE, source2_DECODE, store_DECODE, mul_op_DECODE,
             destination_EXECUTE, memread_EXECUTE, mul_start_EXECUTE,
             branch_taken_EXECUTE,
      output stall_FETCH, stall_DECODE, bubble_EXECUTE, flush_FETCH,
             flush_DECODE, mul_busy, mul_done, stall_cycles, protocol_error
   );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. Resolves load-use and
// multiplier (structural + RAW) hazards by freezing FETCH/DECODE and
// bubbling EXECUTE; taken branches flush and override any stall.
module pipeline_hazard_controller #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MUL_LATENCY    = 4,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                         clock,
   input  logic                         reset_n,
   pipeline_hazard_controller_if.slave  hz
);
   localparam int CNT_W = $clog2(MUL_LATENCY);

   typedef enum logic {
      MUL_IDLE,
      MUL_BUSY
   } mul_state_t;

   mul_state_t                state, state_next;
   logic [CNT_W-1:0]          cnt, cnt_next;
   logic [REG_ADDR_WIDTH-1:0] pending_dest, pending_next;
   logic [COUNT_WIDTH-1:0]    stall_count;
   logic                      proto_err;
   logic                      load_use, mul_hazard, mul_busy_c, mul_done_c;
   logic                      start_ok, illegal, stall;

   function automatic logic reg_match(
      input logic [REG_ADDR_WIDTH-1:0] r,
      input logic [REG_ADDR_WIDTH-1:0] s1,
      input logic [REG_ADDR_WIDTH-1:0] s2,
      input logic [REG_ADDR_WIDTH-1:0] st
   );
      return (r != '0) && ((r == s1) || (r == s2) || (r == st));
   endfunction

   // Hazard detection and multiplier next-state/outputs.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      pending_next = pending_dest;
      mul_busy_c   = 1'b0;
      mul_done_c   = 1'b0;
      mul_hazard   = 1'b0;

      load_use = hz.memread_EXECUTE &&
                 reg_match(hz.destination_EXECUTE, hz.source1_DECODE,
                           hz.source2_DECODE, hz.store_DECODE);
      start_ok = hz.mul_start_EXECUTE && !hz.branch_taken_EXECUTE;
      illegal  = hz.mul_start_EXECUTE &&
                 ((state == MUL_BUSY) || hz.branch_taken_EXECUTE);

      unique case (state)
         MUL_IDLE: begin
            if (start_ok) begin
               state_next   = MUL_BUSY;
               cnt_next     = CNT_W'(MUL_LATENCY - 1);
               pending_next = hz.destination_EXECUTE;
            end
         end
         MUL_BUSY: begin
            mul_busy_c = 1'b1;
            mul_hazard = hz.mul_op_DECODE ||
                         reg_match(pending_dest, hz.source1_DECODE,
                                   hz.source2_DECODE, hz.store_DECODE);
            if (cnt == '0) begin
               mul_done_c = 1'b1;
               state_next = MUL_IDLE;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: state_next = MUL_IDLE;
      endcase

      // Gated by reset_n so a reset clears the combinational outputs at once.
      stall = reset_n && (load_use || mul_hazard) && !hz.branch_taken_EXECUTE;
   end

   // Multiplier FSM state, countdown and pending destination register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= MUL_IDLE;
         cnt          <= '0;
         pending_dest <= '0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         pending_dest <= pending_next;
      end
   end

   // Saturating stall counter and sticky protocol-error flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
         proto_err   <= 1'b0;
      end else begin
         if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
         if (illegal)
            proto_err <= 1'b1;
      end
   end

   assign hz.stall_FETCH    = stall;
   assign hz.stall_DECODE   = stall;
   assign hz.bubble_EXECUTE = stall;
   assign hz.flush_FETCH    = reset_n && hz.branch_taken_EXECUTE;
   assign hz.flush_DECODE   = reset_n && hz.branch_taken_EXECUTE;
   assign hz.mul_busy       = mul_busy_c;
   assign hz.mul_done       = mul_done_c;
   assign hz.stall_cycles   = stall_count;
   assign hz.protocol_error = proto_err;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboarded directed bench for pipeline_hazard_controller.
module tb_pipeline_hazard_controller;
   localparam int RA  = 5;
   localparam int LAT = 4;
   localparam int CW  = 16;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   pipeline_hazard_controller_if #(.REG_ADDR_WIDTH(RA), .COUNT_WIDTH(CW)) hz ();

   pipeline_hazard_controller #(
      .REG_ADDR_WIDTH(RA),
      .MUL_LATENCY   (LAT),
      .COUNT_WIDTH   (CW)
   ) u_dut (
      .clock  (clock),
      .reset_n(reset_n),
      .hz     (hz)
   );

   typedef struct {
      string         name;
      logic          stall;
      logic          flush;
      logic          busy;
      logic          done;
      logic [CW-1:0] cyc;
      logic          perr;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic cmp(input string nm, input string f,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, f, act, exp);
      end
   endtask

   // Monitor: every cycle with a queued expectation, sample mid-cycle and compare.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp(e.name, "stall_FETCH",    32'(hz.stall_FETCH),    32'(e.stall));
         cmp(e.name, "stall_DECODE",   32'(hz.stall_DECODE),   32'(e.stall));
         cmp(e.name, "bubble_EXECUTE", 32'(hz.bubble_EXECUTE), 32'(e.stall));
         cmp(e.name, "flush_FETCH",    32'(hz.flush_FETCH),    32'(e.flush));
         cmp(e.name, "flush_DECODE",   32'(hz.flush_DECODE),   32'(e.flush));
         cmp(e.name, "mul_busy",       32'(hz.mul_busy),       32'(e.busy));
         cmp(e.name, "mul_done",       32'(hz.mul_done),       32'(e.done));
         cmp(e.name, "stall_cycles",   32'(hz.stall_cycles),   32'(e.cyc));
         cmp(e.name, "protocol_error", 32'(hz.protocol_error), 32'(e.perr));
      end
   end

   task automatic drive(input logic rst,
                        input logic [RA-1:0] s1, input logic [RA-1:0] s2,
                        input logic [RA-1:0] st, input logic mop,
                        input logic [RA-1:0] dst, input logic mr,
                        input logic ms, input logic br);
      reset_n                 = rst;
      hz.source1_DECODE       = s1;
      hz.source2_DECODE       = s2;
      hz.store_DECODE         = st;
      hz.mul_op_DECODE        = mop;
      hz.destination_EXECUTE  = dst;
      hz.memread_EXECUTE      = mr;
      hz.mul_start_EXECUTE    = ms;
      hz.branch_taken_EXECUTE = br;
   endtask

   // Apply one cycle of inputs and queue the hand-computed response for it.
   task automatic step(input string nm, input logic rst,
                       input logic [RA-1:0] s1, input logic [RA-1:0] s2,
                       input logic [RA-1:0] st, input logic mop,
                       input logic [RA-1:0] dst, input logic mr,
                       input logic ms, input logic br,
                       input logic e_stall, input logic e_flush,
                       input logic e_busy, input logic e_done,
                       input logic [CW-1:0] e_cyc, input logic e_perr);
      exp_t e;
      drive(rst, s1, s2, st, mop, dst, mr, ms, br);
      e.name = nm; e.stall = e_stall; e.flush = e_flush; e.busy = e_busy;
      e.done = e_done; e.cyc = e_cyc; e.perr = e_perr;
      sb.push_back(e);
      @(posedge clock);
      #1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      @(posedge clock); #1;
      //    name            rst s1 s2 st mop dst mr ms br   stl fl bz dn cyc  pe
      step("reset",         0,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0,   0);
      step("idle",          1,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0,   0);
      step("load_use",      1,  5, 0, 0, 0,  5, 1, 0, 0,   1, 0, 0, 0, 0,   0);
      step("lu_release",    1,  5, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 1,   0);
      step("r0_guard",      1,  3, 0, 0, 0,  0, 1, 0, 0,   0, 0, 0, 0, 1,   0);
      step("load_store",    1,  1, 2, 7, 0,  7, 1, 0, 0,   1, 0, 0, 0, 1,   0);
      step("idle2",         1,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 2,   0);
      step("mul_start",     1,  0, 0, 0, 0,  9, 0, 1, 0,   0, 0, 0, 0, 2,   0);
      step("mul_raw1",      1,  0, 0, 9, 0,  0, 0, 0, 0,   1, 0, 1, 0, 2,   0);
      step("mul_raw2",      1,  0, 0, 9, 0,  0, 0, 0, 0,   1, 0, 1, 0, 3,   0);
      step("mul_raw3",      1,  0, 0, 9, 0,  0, 0, 0, 0,   1, 0, 1, 0, 4,   0);
      step("mul_raw_done",  1,  0, 0, 9, 0,  0, 0, 0, 0,   1, 0, 1, 1, 5,   0);
      step("mul_release",   1,  0, 0, 9, 0,  0, 0, 0, 0,   0, 0, 0, 0, 6,   0);
      step("smul_start",    1,  0, 0, 0, 0,  0, 0, 1, 0,   0, 0, 0, 0, 6,   0);
      step("smul_b1",       1,  0, 0, 0, 1,  0, 0, 0, 0,   1, 0, 1, 0, 6,   0);
      step("smul_restart",  1,  0, 0, 0, 1,  4, 0, 1, 0,   1, 0, 1, 0, 7,   0);
      step("smul_b3",       1,  0, 0, 0, 1,  0, 0, 0, 0,   1, 0, 1, 0, 8,   1);
      step("smul_done",     1,  0, 0, 0, 1,  0, 0, 0, 0,   1, 0, 1, 1, 9,   1);
      step("smul_release",  1,  0, 0, 0, 1,  0, 0, 0, 0,   0, 0, 0, 0, 10,  1);
      step("bmul_start",    1,  0, 0, 0, 0,  6, 0, 1, 0,   0, 0, 0, 0, 10,  1);
      step("br_over_lu",    1,  3, 0, 0, 0,  3, 1, 0, 1,   0, 1, 1, 0, 10,  1);
      step("bmul_raw",      1,  6, 0, 0, 0,  0, 0, 0, 0,   1, 0, 1, 0, 10,  1);
      step("br_over_mul",   1,  6, 0, 0, 0,  0, 0, 0, 1,   0, 1, 1, 0, 11,  1);
      step("bmul_done",     1,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 1, 1, 11,  1);
      step("bmul_idle",     1,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 11,  1);
      step("rmul_start",    1,  0, 0, 0, 0,  2, 0, 1, 0,   0, 0, 0, 0, 11,  1);
      step("rmul_busy",     1,  2, 0, 0, 0,  0, 0, 0, 0,   1, 0, 1, 0, 11,  1);
      step("reset_mid",     0,  2, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0,   0);
      step("post_reset",    1,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0,   0);
      step("start_br",      1,  0, 0, 0, 0,  8, 0, 1, 1,   0, 1, 0, 0, 0,   0);
      step("start_br_after",1,  8, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0,   1);

      // Hold a load-use hazard for exactly 65535 cycles to reach all-ones.
      drive(1'b1, 5'd5, '0, '0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      repeat (65535) @(posedge clock);
      #1;
      step("sat_hold",      1,  5, 0, 0, 0,  5, 1, 0, 0,   1, 0, 0, 0, 16'hFFFF, 1);
      step("sat_hold2",     1,  5, 0, 0, 0,  5, 1, 0, 0,   1, 0, 0, 0, 16'hFFFF, 1);
      step("sat_idle",      1,  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 16'hFFFF, 1);

      repeat (2) @(posedge clock);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
